// File: rtl/alu_exec_if.sv
// Operation, register-file and status bundle between the op issuer/register file (master)
// and the alu_exec execute/writeback stage (slave).
interface alu_exec_if #(
  parameter int DW = 16,
  parameter int AW = 2
) ();
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    opcode;
  logic [AW-1:0] src1;
  logic [AW-1:0] src2;
  logic [AW-1:0] dst;
  logic [AW-1:0] r_add1;
  logic [AW-1:0] r_add2;
  logic [DW-1:0] r_data1;
  logic [DW-1:0] r_data2;
  logic [AW-1:0] w_add;
  logic          w_flag;
  logic [DW-1:0] w_data;
  logic          done;
  logic          err;
  logic          flag_z;
  logic          flag_c;

  modport master (
    output op_valid, opcode, src1, src2, dst, r_data1, r_data2,
    input  op_ready, r_add1, r_add2, w_add, w_flag, w_data, done, err, flag_z, flag_c
  );

  modport slave (
    input  op_valid, opcode, src1, src2, dst, r_data1, r_data2,
    output op_ready, r_add1, r_add2, w_add, w_flag, w_data, done, err, flag_z, flag_c
  );
endinterface

// File: rtl/alu_exec.sv
// Serial execute/writeback stage for a 4 x 16-bit register file: IDLE->READ->EXEC->(MULT)->WB.
// Define ALU_MUL_EN to build the shift-add multiplier; otherwise opcode 111 reports err.
module alu_exec #(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  alu_exec_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
`ifdef ALU_MUL_EN
  localparam logic [2:0] S_MULT = 3'd3;
`endif
  localparam logic [2:0] S_WB   = 3'd4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [2:0]    opc_q, opc_d;
  logic [AW-1:0] src1_q, src1_d;
  logic [AW-1:0] src2_q, src2_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] r_q, r_d;
  logic [AW-1:0] w_add_q, w_add_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_c_q, flag_c_d;
`ifdef ALU_MUL_EN
  logic [DW-1:0] acc_q, acc_d;
  logic [3:0]    cnt_q, cnt_d;
`endif

  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          wb_load;
  logic [DW-1:0] wb_res;
  logic          wb_c;

  // Single-cycle ops; carry is only recomputed for ADD/SUB, otherwise it passes through.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    alu_res = '0;
    alu_c   = flag_c_q;
    case (opc_q)
      OP_ADD: begin
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      OP_SUB: begin
        alu_res = diff[DW-1:0];
        alu_c   = diff[DW];
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SHL:  alu_res = a_q << b_q[3:0];
      OP_SHR:  alu_res = a_q >> b_q[3:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    dst_d    = dst_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    w_add_d  = w_add_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    wb_load  = 1'b0;
    wb_res   = alu_res;
    wb_c     = alu_c;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          opc_d   = bus.opcode;
          src1_d  = bus.src1;
          src2_d  = bus.src2;
          dst_d   = bus.dst;
          state_d = S_READ;
        end
      end
      S_READ: begin
        a_d     = bus.r_data1;
        b_d     = bus.r_data2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (opc_q == OP_MUL) begin
`ifdef ALU_MUL_EN
          acc_d   = '0;
          cnt_d   = 4'd15;
          state_d = S_MULT;
`else
          state_d = S_IDLE;
`endif
        end else begin
          wb_load = 1'b1;
          state_d = S_WB;
        end
      end
`ifdef ALU_MUL_EN
      // One multiplier bit per cycle; the cnt==0 iteration is the 16th and hands acc to WB.
      S_MULT: begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          wb_load = 1'b1;
          wb_res  = acc_d;
          wb_c    = flag_c_q;
          state_d = S_WB;
        end
      end
`endif
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wb_load) begin
      r_d      = wb_res;
      w_add_d  = dst_q;
      flag_z_d = (wb_res == '0);
      flag_c_d = wb_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      opc_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      w_add_q  <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      dst_q    <= dst_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      w_add_q  <= w_add_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  // w_add/w_data are registered at WB entry so they hold between writes; w_flag qualifies them.
  assign bus.op_ready = (state_q == S_IDLE);
  assign bus.r_add1   = src1_q;
  assign bus.r_add2   = src2_q;
  assign bus.w_add    = w_add_q;
  assign bus.w_data   = r_q;
  assign bus.w_flag   = (state_q == S_WB);
  assign bus.flag_z   = flag_z_q;
  assign bus.flag_c   = flag_c_q;
`ifdef ALU_MUL_EN
  assign bus.err      = 1'b0;
`else
  assign bus.err      = (state_q == S_EXEC) && (opc_q == OP_MUL);
`endif
  assign bus.done     = bus.w_flag | bus.err;

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute/writeback stage directly downstream of the 4-entry x 16-bit register file.
- Accepts one decoded operation at a time and drives the register file read addresses.
- Captures both operands, computes the result and writes it back through the register file write port (w_add/w_flag/w_data).
- Single-cycle ops plus an iterative shift-add multiply; serial, one op in flight, no forwarding needed.

Parameters:
- DW, 16, datapath width; matches the register file word.
- AW, 2, register address width (4 registers).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  a decoded op is presented.
- op_ready  out  1  block can accept an op.
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- src1  in  AW  first operand register index.
- src2  in  AW  second operand register index.
- dst  in  AW  destination register index.
- r_add1  out  AW  register file read address 1.
- r_add2  out  AW  register file read address 2.
- r_data1  in  DW  register file read data 1.
- r_data2  in  DW  register file read data 2.
- w_add  out  AW  register file write address.
- w_flag  out  1  register file write enable; one-cycle pulse.
- w_data  out  DW  register file write data.
- done  out  1  one-cycle pulse, coincident with w_flag or err.
- err  out  1  one-cycle pulse on an illegal op; only possible with the macro off.
- flag_z  out  1  zero flag of the last written result.
- flag_c  out  1  carry (ADD) or borrow (SUB) of the last ADD/SUB.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except op_ready=1; operand, result and counter registers 0.
- Reset mid-operation aborts the op: no w_flag, no done.
- States:
  - IDLE: op_ready=1. On op_valid at an edge, latch opcode/src1/src2/dst and go to READ.
  - READ: r_add1/r_add2 come from the latched src1/src2 (held stable until the next accept). Capture r_data1/r_data2 into A/B at the edge, then go to EXEC.
  - EXEC, non-MUL: compute result into R, go to WB.
  - EXEC, MUL: clear the accumulator, load counter=15, go to MULT.
  - MULT: each cycle, if B[0] then acc+=A (mod 2^16); A<<=1; B>>=1; counter--. Exit to WB after the counter=0 iteration, i.e. 16 MULT cycles.
  - WB: w_flag=1, w_add=dst, w_data=R; update flag_z (and flag_c for ADD/SUB); done=1; return to IDLE.
- op_ready is 0 in every state except IDLE. op_valid outside IDLE is ignored, not queued.
- Latency from the accept edge (cycle 0):
  - Non-MUL: READ in cycle 1, EXEC in cycle 2, w_flag high in cycle 3.
  - MUL: w_flag high in cycle 19.
  - Earliest next accept: the edge ending WB, i.e. back-to-back ops every 4 cycles.
- Arithmetic, all results truncated to DW bits:
  - ADD: flag_c = bit 16 of A+B.
  - SUB: A-B mod 2^16; flag_c=1 iff A<B unsigned.
  - SHL/SHR: logical shift of A by B[3:0]; shift amount 0 gives A unchanged.
  - MUL: low 16 bits of the product.
- flag_c holds its value across non-ADD/SUB ops. flag_z=1 iff R==0.
- src1==src2 is legal; both operands equal the same register.
- dst equal to a source is legal; the write happens after both reads are captured.
- The register file write must be visible to a read address presented in the next op's READ cycle.
- w_add/w_data hold their last values outside WB. Only w_flag qualifies them.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: MUL supported as above, with the MULT state, 16-bit accumulator and 4-bit counter.
- Undefined: no MULT logic is built. Opcode 111 goes EXEC -> IDLE with err=1 and done=1 for one cycle (cycle 2 after accept), no w_flag, flags unchanged.

Test Plan:
- Reset: hold reset_n=0 mid-MUL (reg1=3, reg2=5) -> w_flag never pulses; op_ready=1; w_flag/done/err/flag_z/flag_c=0; after release, next ADD works normally.
- ADD with carry: reg1=0xFFFF, reg2=0x0001, ADD dst=3 -> cycle 3: w_flag=1, w_add=3, w_data=0x0000, flag_z=1, flag_c=1.
- SUB with borrow: reg0=0x0005, reg1=0x0007, SUB src1=0 src2=1 dst=2 -> w_data=0xFFFE, flag_c=1, flag_z=0. A following AND leaves flag_c=1.
- MUL (macro on): reg1=0x0123, reg2=0x0045, MUL dst=0 -> w_flag exactly at cycle 19, w_data=0x4E6F. Also 0xFFFF*0xFFFF -> 0x0001.
- Back-to-back dependency: ADD r1=r1+r1 with r1=2, then immediately SHL r2=r1<<r1 -> second op reads 4 and writes 0x0040; op_ready low during cycles 1-3; op_valid held during the busy cycles accepted only once.
- Macro off: MUL opcode -> err=1 and done=1 at cycle 2, no w_flag, op_ready high at cycle 3.
